ex_mem_stage_reg: RTL and testbench

Parametrised EX/MEM pipeline stage register. It adds a valid/ready handshake, a flush input, and an optional 2-entry skid buffer, so the memory stage can stall without a combinational ready path back into EX. It sits between the ALU/forwarding logic and the data-memory stage. It also exports the stage's forwarding source (destination, value, write-enable) to the forwarding unit.

---
 rtl/ex_mem_pkg.sv | 20 ++
 rtl/pipe_payload_reg.sv | 28 ++
 rtl/ex_mem_stage_reg.sv | 110 +++++++++++
 tb/tb_ex_mem_stage_reg.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM stage register: control bit map and payload layout.
package ex_mem_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 5;

  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_IMM      = 4;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] lui;
    logic [REG_W-1:0]  dest;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;
endpackage

// File: rtl/pipe_payload_reg.sv
// One pipeline entry: payload register with load enable plus its valid bit.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         valid_d_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d_i;
      if (load_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM stage register with valid/ready handshake, flush, optional skid entry
// and the forwarding-source view of the held instruction.
module ex_mem_stage_reg
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = ex_mem_pkg::DATA_W,
  parameter int REG_W  = ex_mem_pkg::REG_W,
  parameter int CTRL_W = ex_mem_pkg::CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [DATA_W-1:0] in_lui,
  input  logic [REG_W-1:0]  in_dest,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [DATA_W-1:0] out_lui,
  output logic [REG_W-1:0]  out_dest,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              fwd_we,
  output logic [REG_W-1:0]  fwd_dest,
  output logic [DATA_W-1:0] fwd_value
);
  localparam int PW = 3*DATA_W + REG_W + CTRL_W;

  logic [PW-1:0]     in_pay, main_pay, skid_pay, main_src;
  logic              main_valid, skid_valid;
  logic              main_valid_d, skid_valid_d;
  logic              main_load, skid_load;
  logic              accept, consume, main_free;
  logic [CTRL_W-1:0] main_ctrl;

  assign in_pay = {in_alu_result, in_store_data, in_lui, in_dest, in_ctrl};

  always_comb begin
    accept       = in_valid & in_ready;
    consume      = main_valid & out_ready;
    main_free    = ~main_valid | consume;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    main_load    = 1'b0;
    skid_load    = 1'b0;
    main_src     = in_pay;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      // The skid entry is older than anything on the input, so it drains first.
      if (skid_valid) begin
        main_src     = skid_pay;
        main_load    = 1'b1;
        main_valid_d = 1'b1;
        skid_load    = accept;
        skid_valid_d = accept;
      end else begin
        main_load    = accept;
        main_valid_d = accept;
      end
    end else if (accept) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  pipe_payload_reg #(.W(PW)) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (main_load),
    .data_i    (main_src),
    .valid_d_i (main_valid_d),
    .valid_o   (main_valid),
    .data_o    (main_pay)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_payload_reg #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (skid_load),
        .data_i    (in_pay),
        .valid_d_i (skid_valid_d),
        .valid_o   (skid_valid),
        .data_o    (skid_pay)
      );
      // Registered ready: no combinational path from out_ready back into EX.
      assign in_ready = ~skid_valid;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_pay   = '0;
      assign in_ready   = ~main_valid | out_ready;
    end
  endgenerate

  assign {out_alu_result, out_store_data, out_lui, out_dest, main_ctrl} = main_pay;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;

  assign fwd_we    = out_ctrl[CTRL_REGWRITE] & (out_dest != '0);
  assign fwd_dest  = out_dest;
  assign fwd_value = out_ctrl[CTRL_IMM] ? out_lui : out_alu_result;
endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: SKID=1 and SKID=0 builds driven together and
// checked against a FIFO-queue model every cycle, plus directed literal checks.
module tb_ex_mem_stage_reg;
  import ex_mem_pkg::*;

  localparam logic [4:0] RW  = 5'b01000;
  localparam logic [4:0] IMM = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, in_valid, out_ready;
  logic [31:0] alu, sd, lui;
  logic [4:0]  dest, ctrl;

  logic        r1, ov1, fwe1, r0, ov0, fwe0;
  logic [31:0] alu1, sd1, lui1, fv1, alu0, sd0, lui0, fv0;
  logic [4:0]  d1, c1, fd1, d0, c0, fd0;

  int nchk = 0;
  int nfail = 0;

  payload_t cur;
  payload_t q1[$];
  payload_t q0[$];
  bit acc1, con1, acc0, con0;

  always #5 clk = ~clk;

  assign cur = {alu, sd, lui, dest, ctrl};

  ex_mem_stage_reg #(.SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(r1),
    .in_alu_result(alu), .in_store_data(sd), .in_lui(lui), .in_dest(dest), .in_ctrl(ctrl),
    .out_valid(ov1), .out_ready(out_ready), .out_alu_result(alu1), .out_store_data(sd1),
    .out_lui(lui1), .out_dest(d1), .out_ctrl(c1), .fwd_we(fwe1), .fwd_dest(fd1), .fwd_value(fv1));

  ex_mem_stage_reg #(.SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(r0),
    .in_alu_result(alu), .in_store_data(sd), .in_lui(lui), .in_dest(dest), .in_ctrl(ctrl),
    .out_valid(ov0), .out_ready(out_ready), .out_alu_result(alu0), .out_store_data(sd0),
    .out_lui(lui0), .out_dest(d0), .out_ctrl(c0), .fwd_we(fwe0), .fwd_dest(fd0), .fwd_value(fv0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a FIFO of accepted entries; capacity 2 with skid, 1 without.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1.delete();
      q0.delete();
    end else begin
      acc1 = in_valid && (q1.size() < 2);
      con1 = (q1.size() > 0) && out_ready;
      acc0 = in_valid && ((q0.size() == 0) || out_ready);
      con0 = (q0.size() > 0) && out_ready;
      if (flush_i) begin
        q1.delete();
        q0.delete();
      end else begin
        if (con1) void'(q1.pop_front());
        if (acc1) q1.push_back(cur);
        if (con0) void'(q0.pop_front());
        if (acc0) q0.push_back(cur);
      end
    end
  end

  task automatic cmp(input string t, input int sz, input payload_t h, input logic exp_rdy,
                     input logic rdy, input logic ov, input logic [31:0] a, input logic [31:0] s,
                     input logic [31:0] l, input logic [4:0] d, input logic [4:0] c,
                     input logic fwe, input logic [4:0] fd, input logic [31:0] fv);
    chk({t, " in_ready"}, {31'b0, rdy}, {31'b0, exp_rdy});
    chk({t, " out_valid"}, {31'b0, ov}, {31'b0, sz > 0});
    if (sz > 0) begin
      chk({t, " alu"}, a, h.alu_result);
      chk({t, " store"}, s, h.store_data);
      chk({t, " lui"}, l, h.lui);
      chk({t, " dest"}, {27'b0, d}, {27'b0, h.dest});
      chk({t, " ctrl"}, {27'b0, c}, {27'b0, h.ctrl});
      chk({t, " fwd_dest"}, {27'b0, fd}, {27'b0, h.dest});
      chk({t, " fwd_we"}, {31'b0, fwe}, {31'b0, h.ctrl[CTRL_REGWRITE] && (h.dest != 5'd0)});
      chk({t, " fwd_value"}, fv, h.ctrl[CTRL_IMM] ? h.lui : h.alu_result);
    end else begin
      chk({t, " bubble ctrl"}, {27'b0, c}, 32'd0);
      chk({t, " bubble fwd_we"}, {31'b0, fwe}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp("skid1", q1.size(), (q1.size() > 0) ? q1[0] : '0, q1.size() < 2,
          r1, ov1, alu1, sd1, lui1, d1, c1, fwe1, fd1, fv1);
      cmp("skid0", q0.size(), (q0.size() > 0) ? q0[0] : '0, (q0.size() == 0) || out_ready,
          r0, ov0, alu0, sd0, lui0, d0, c0, fwe0, fd0, fv0);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] a, input logic [4:0] d,
                     input logic [4:0] c, input logic [31:0] l);
    in_valid = v;
    alu      = a;
    sd       = a ^ 32'hFFFF_0000;
    dest     = d;
    ctrl     = c;
    lui      = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
    put(1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    cyc(); cyc();
    chk("reset in_ready", {31'b0, r1}, 32'd1);
    chk("reset out_valid", {31'b0, ov1}, 32'd0);
    chk("reset out_ctrl", {27'b0, c1}, 32'd0);
    chk("reset fwd_we", {31'b0, fwe1}, 32'd0);
    rst_n = 1'b1;

    // Streaming with the consumer always ready
    out_ready = 1'b1;
    put(1'b1, 32'h10, 5'd3, RW, 32'h0);
    cyc();
    chk("stream out_valid", {31'b0, ov1}, 32'd1);
    chk("stream alu", alu1, 32'h10);
    chk("stream fwd_we", {31'b0, fwe1}, 32'd1);
    chk("stream fwd_dest", {27'b0, fd1}, 32'd3);
    chk("stream in_ready", {31'b0, r1}, 32'd1);
    cyc(); cyc();
    put(1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    cyc();

    // Stall fill: A then B with consumer stalled
    out_ready = 1'b0;
    put(1'b1, 32'hA, 5'd1, RW, 32'h0);
    cyc();
    put(1'b1, 32'hB, 5'd2, RW, 32'h0);
    cyc();
    chk("fill in_ready", {31'b0, r1}, 32'd0);
    chk("fill out A", alu1, 32'hA);
    put(1'b1, 32'hC, 5'd4, RW, 32'h0);
    cyc();
    chk("fill hold A", alu1, 32'hA);
    put(1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    out_ready = 1'b1;
    cyc();
    chk("drain out B", alu1, 32'hB);
    chk("drain in_ready", {31'b0, r1}, 32'd1);
    cyc();
    chk("drain empty", {31'b0, ov1}, 32'd0);

    // Flush with both entries full and a new input offered
    out_ready = 1'b0;
    put(1'b1, 32'hA1, 5'd1, 5'b01010, 32'h0);
    cyc();
    put(1'b1, 32'hB1, 5'd2, 5'b01010, 32'h0);
    cyc();
    flush_i = 1'b1;
    put(1'b1, 32'hC1, 5'd5, 5'b00010, 32'h0);
    cyc();
    flush_i = 1'b0;
    put(1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    chk("flush out_valid", {31'b0, ov1}, 32'd0);
    chk("flush out_ctrl", {27'b0, c1}, 32'd0);
    chk("flush in_ready", {31'b0, r1}, 32'd1);
    out_ready = 1'b1;
    cyc();
    chk("flush no C", {31'b0, ov1}, 32'd0);
    // Flush into an empty stage: the same-cycle accept is discarded
    flush_i = 1'b1;
    put(1'b1, 32'hD1, 5'd6, RW, 32'h0);
    cyc();
    flush_i = 1'b0;
    put(1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    chk("flush accept dropped", {31'b0, ov1}, 32'd0);

    // LUI forwarding, then the same entry targeting r0
    out_ready = 1'b0;
    put(1'b1, 32'h5, 5'd7, IMM | RW, 32'h1234_0000);
    cyc();
    put(1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    chk("lui fwd_value", fv1, 32'h1234_0000);
    chk("lui fwd_we", {31'b0, fwe1}, 32'd1);
    out_ready = 1'b1;
    put(1'b1, 32'h5, 5'd0, IMM | RW, 32'h1234_0000);
    cyc();
    out_ready = 1'b0;
    put(1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    chk("r0 fwd_we", {31'b0, fwe1}, 32'd0);
    chk("r0 fwd_value", fv1, 32'h1234_0000);
    out_ready = 1'b1;
    cyc();

    // Async reset while both entries are held
    out_ready = 1'b0;
    put(1'b1, 32'hE, 5'd8, RW, 32'h0);
    cyc();
    put(1'b1, 32'hF, 5'd9, 5'b01010, 32'h0);
    cyc();
    put(1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", {31'b0, ov1}, 32'd0);
    chk("async out_ctrl", {27'b0, c1}, 32'd0);
    chk("async in_ready", {31'b0, r1}, 32'd1);
    chk("async skid0 out_valid", {31'b0, ov0}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Combinational ready of the single-entry build
    out_ready = 1'b0;
    put(1'b1, 32'h60, 5'd10, RW, 32'h0);
    cyc();
    put(1'b1, 32'h61, 5'd11, RW, 32'h0);
    #1;
    chk("noskid ready low", {31'b0, r0}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("noskid ready comb", {31'b0, r0}, 32'd1);
    cyc();
    put(1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    chk("noskid new entry", alu0, 32'h61);
    cyc();

    // Mixed traffic pattern, checked by the model each cycle
    for (int i = 0; i < 48; i++) begin
      out_ready = (i % 4) < 2;
      flush_i   = (i == 30);
      put((i % 3) != 0, 32'h100 + i, 5'(i % 8), 5'(i % 32), 32'h0001_0000 * i);
      cyc();
    end
    flush_i = 1'b0;
    out_ready = 1'b1;
    put(1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    cyc(); cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
